// File: rtl/ecc_point_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ecc_point_unit_if
// Description : Handshake and data bundle for ecc_point_unit.
//               master = requester (scalar-multiplication controller),
//               slave  = ecc_point_unit.
//   in_valid        single-cycle start strobe
//   mode            0 = add (P+Q), 1 = double (2P)
//   Px, Py, Qx, Qy  operand coordinates (< PRIME)
//   P_inf, Q_inf    operand is the point at infinity
//   busy            operation in progress
//   out_valid       one-cycle result strobe
//   Rx, Ry, R_inf   result point
//   err             unsupported case, valid with out_valid
// Revision    : 1.0 - initial release
// ============================================================================
interface ecc_point_unit_if #(
  parameter int WIDTH = 256
);
  logic             in_valid;
  logic             mode;
  logic [WIDTH-1:0] Px;
  logic [WIDTH-1:0] Py;
  logic [WIDTH-1:0] Qx;
  logic [WIDTH-1:0] Qy;
  logic             P_inf;
  logic             Q_inf;
  logic             busy;
  logic             out_valid;
  logic [WIDTH-1:0] Rx;
  logic [WIDTH-1:0] Ry;
  logic             R_inf;
  logic             err;

  modport master (
    output in_valid, mode, Px, Py, Qx, Qy, P_inf, Q_inf,
    input  busy, out_valid, Rx, Ry, R_inf, err
  );

  modport slave (
    input  in_valid, mode, Px, Py, Qx, Qy, P_inf, Q_inf,
    output busy, out_valid, Rx, Ry, R_inf, err
  );
endinterface
`default_nettype wire

// File: rtl/ecc_point_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ecc_point_unit
// Description : Affine short-Weierstrass point adder / doubler
//               (y^2 = x^3 + A*x + B mod PRIME) with explicit handling of the
//               point at infinity. One shared bit-serial modular multiplier
//               and a binary extended-Euclid inverter, sequenced by an FSM.
// Ports       : clk  - clock
//               rst  - synchronous reset, active-high
//               bus  - ecc_point_unit_if.slave (operands, strobes, result)
// Parameters  : WIDTH (field width), PRIME (odd modulus), A (curve coeff a)
// Build macro : ECC_DBL_EN - builds the doubling datapath (3*Px^2+A, 2*Py).
//               When undefined, doubling requests return err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_point_unit #(
  parameter int               WIDTH = 256,
  parameter logic [WIDTH-1:0] PRIME = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
  parameter logic [WIDTH-1:0] A     = '0
) (
  input  logic               clk,
  input  logic               rst,
  ecc_point_unit_if.slave    bus
);

  localparam int               c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] c_one   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CHECK  = 4'd1,
    S_PREP   = 4'd2,
    S_INV    = 4'd3,
    S_LAMBDA = 4'd4,
    S_LSQ    = 4'd5,
    S_RX     = 4'd6,
    S_RY     = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  // --------------------------------------------------------------------------
  // Modular helpers; all operands are assumed to lie in [0, PRIME).
  // --------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] f_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, PRIME}) s = s - {1'b0, PRIME};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] f_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} - {1'b0, b};
    // Borrow out of the top bit means a < b: fold back by adding PRIME.
    if (s[WIDTH]) s = s + {1'b0, PRIME};
    return s[WIDTH-1:0];
  endfunction

  // x/2 mod PRIME: odd values become even by adding the (odd) modulus first.
  function automatic logic [WIDTH-1:0] f_half(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] s;
    s = {1'b0, x};
    if (x[0]) s = s + {1'b0, PRIME};
    s = s >> 1;
    return s[WIDTH-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   rx_q, rx_d;
  logic [WIDTH-1:0]   ry_q, ry_d;
  logic               r_inf_q, r_inf_d;
  logic               err_q, err_d;

  logic               mode_q, mode_d;
  logic               p_inf_q, p_inf_d;
  logic               q_inf_q, q_inf_d;
  logic [WIDTH-1:0]   px_q, px_d;
  logic [WIDTH-1:0]   py_q, py_d;
  logic [WIDTH-1:0]   qx_q, qx_d;
  logic [WIDTH-1:0]   qy_q, qy_d;
`ifdef ECC_DBL_EN
  logic               dbl_q, dbl_d;
`endif

  // Result staging; copied to the output registers only in DONE so the
  // visible result holds until the next completion.
  logic [WIDTH-1:0]   res_x_q, res_x_d;
  logic [WIDTH-1:0]   res_y_q, res_y_d;
  logic               res_inf_q, res_inf_d;
  logic               res_err_q, res_err_d;

  // Working registers: num = lambda numerator, lam = lambda,
  // tmp = inverse, then lambda^2, then (Px - Rx).
  logic [WIDTH-1:0]   num_q, num_d;
  logic [WIDTH-1:0]   lam_q, lam_d;
  logic [WIDTH-1:0]   tmp_q, tmp_d;

  // Inverter: invariants x1*den == u and x2*den == v (mod PRIME).
  logic [WIDTH-1:0]   u_q, u_d;
  logic [WIDTH-1:0]   v_q, v_d;
  logic [WIDTH-1:0]   x1_q, x1_d;
  logic [WIDTH-1:0]   x2_q, x2_d;

  // Shared multiplier
  logic               mul_pend_q, mul_pend_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [WIDTH-1:0]   mul_acc_q, mul_acc_d;
  logic [c_cnt_w-1:0] mul_cnt_q, mul_cnt_d;
  logic               mul_run_q, mul_run_d;
  logic               mul_done_q, mul_done_d;

  logic               mul_start;
  logic [WIDTH-1:0]   mul_op_a;
  logic [WIDTH-1:0]   mul_op_b;
  logic [WIDTH-1:0]   mul_dbl;
  logic [WIDTH-1:0]   mul_step;
  logic [WIDTH-1:0]   rx_new;
  logic               eq_x;
  logic               eq_y;
  logic               py_zero;

  // MSB-first interleaved multiply step: acc = 2*acc (+ a if b bit set).
  assign mul_dbl  = f_add(mul_acc_q, mul_acc_q);
  assign mul_step = mul_b_q[WIDTH-1] ? f_add(mul_dbl, mul_a_q) : mul_dbl;

  assign rx_new  = f_sub(f_sub(tmp_q, px_q), qx_q);
  assign eq_x    = (px_q == qx_q);
  assign eq_y    = (py_q == qy_q);
  assign py_zero = (py_q == '0);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    rx_d        = rx_q;
    ry_d        = ry_q;
    r_inf_d     = r_inf_q;
    err_d       = err_q;
    mode_d      = mode_q;
    p_inf_d     = p_inf_q;
    q_inf_d     = q_inf_q;
    px_d        = px_q;
    py_d        = py_q;
    qx_d        = qx_q;
    qy_d        = qy_q;
`ifdef ECC_DBL_EN
    dbl_d       = dbl_q;
`endif
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_inf_d   = res_inf_q;
    res_err_d   = res_err_q;
    num_d       = num_q;
    lam_d       = lam_q;
    tmp_d       = tmp_q;
    u_d         = u_q;
    v_d         = v_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    mul_pend_d  = mul_pend_q;
    mul_start   = 1'b0;
    mul_op_a    = '0;
    mul_op_b    = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mode_d  = bus.mode;
          p_inf_d = bus.P_inf;
          q_inf_d = bus.Q_inf;
          px_d    = bus.Px;
          py_d    = bus.Py;
          qx_d    = bus.Qx;
          qy_d    = bus.Qy;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        res_x_d   = '0;
        res_y_d   = '0;
        res_inf_d = 1'b0;
        res_err_d = 1'b0;
        state_d   = S_DONE;
        if (p_inf_q && (mode_q || q_inf_q)) begin
          res_inf_d = 1'b1;
        end else if (!mode_q && p_inf_q) begin
          res_x_d = qx_q;
          res_y_d = qy_q;
        end else if (!mode_q && q_inf_q) begin
          res_x_d = px_q;
          res_y_d = py_q;
        end else if (!mode_q && eq_x && !eq_y) begin
          res_inf_d = 1'b1;
        end else if (mode_q || eq_x) begin
          // Doubling: explicit request, or an add whose operands coincide.
          if (py_zero) begin
            res_inf_d = 1'b1;
          end else begin
`ifdef ECC_DBL_EN
            dbl_d   = 1'b1;
            qx_d    = px_q;    // lets RX use lambda^2 - Px - Qx uniformly
            qy_d    = py_q;
            state_d = S_PREP;
`else
            res_err_d = 1'b1;
`endif
          end
        end else begin
`ifdef ECC_DBL_EN
          dbl_d   = 1'b0;
`endif
          state_d = S_PREP;
        end
      end

      S_PREP: begin
`ifdef ECC_DBL_EN
        if (dbl_q) begin
          if (!mul_pend_q) begin
            mul_start  = 1'b1;
            mul_op_a   = px_q;
            mul_op_b   = px_q;
            mul_pend_d = 1'b1;
          end else if (mul_done_q) begin
            num_d      = f_add(f_add(f_add(mul_acc_q, mul_acc_q), mul_acc_q), A);
            u_d        = f_add(py_q, py_q);
            v_d        = PRIME;
            x1_d       = c_one;
            x2_d       = '0;
            mul_pend_d = 1'b0;
            state_d    = S_INV;
          end
        end else begin
          num_d   = f_sub(qy_q, py_q);
          u_d     = f_sub(qx_q, px_q);
          v_d     = PRIME;
          x1_d    = c_one;
          x2_d    = '0;
          state_d = S_INV;
        end
`else
        num_d   = f_sub(qy_q, py_q);
        u_d     = f_sub(qx_q, px_q);
        v_d     = PRIME;
        x1_d    = c_one;
        x2_d    = '0;
        state_d = S_INV;
`endif
      end

      S_INV: begin
        // Each cycle removes at least one bit from u*v, bounding the loop
        // to 2*WIDTH iterations; subtract and halve are fused for that.
        if (u_q == c_one) begin
          tmp_d   = x1_q;
          state_d = S_LAMBDA;
        end else if (v_q == c_one) begin
          tmp_d   = x2_q;
          state_d = S_LAMBDA;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = f_half(x1_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = f_half(x2_q);
        end else if (u_q >= v_q) begin
          u_d  = (u_q - v_q) >> 1;
          x1_d = f_half(f_sub(x1_q, x2_q));
        end else begin
          v_d  = (v_q - u_q) >> 1;
          x2_d = f_half(f_sub(x2_q, x1_q));
        end
      end

      S_LAMBDA: begin
        if (!mul_pend_q) begin
          mul_start  = 1'b1;
          mul_op_a   = num_q;
          mul_op_b   = tmp_q;
          mul_pend_d = 1'b1;
        end else if (mul_done_q) begin
          lam_d      = mul_acc_q;
          mul_pend_d = 1'b0;
          state_d    = S_LSQ;
        end
      end

      S_LSQ: begin
        if (!mul_pend_q) begin
          mul_start  = 1'b1;
          mul_op_a   = lam_q;
          mul_op_b   = lam_q;
          mul_pend_d = 1'b1;
        end else if (mul_done_q) begin
          tmp_d      = mul_acc_q;
          mul_pend_d = 1'b0;
          state_d    = S_RX;
        end
      end

      S_RX: begin
        res_x_d = rx_new;
        tmp_d   = f_sub(px_q, rx_new);
        state_d = S_RY;
      end

      S_RY: begin
        if (!mul_pend_q) begin
          mul_start  = 1'b1;
          mul_op_a   = lam_q;
          mul_op_b   = tmp_q;
          mul_pend_d = 1'b1;
        end else if (mul_done_q) begin
          res_y_d    = f_sub(mul_acc_q, py_q);
          mul_pend_d = 1'b0;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        rx_d        = res_x_q;
        ry_d        = res_y_q;
        r_inf_d     = res_inf_q;
        err_d       = res_err_q;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Multiplier engine: one load cycle, then WIDTH shift-add-reduce cycles;
    // mul_done_q flags the cycle in which mul_acc_q holds the product.
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_acc_d  = mul_acc_q;
    mul_cnt_d  = mul_cnt_q;
    mul_run_d  = mul_run_q;
    mul_done_d = 1'b0;
    if (mul_start) begin
      mul_a_d   = mul_op_a;
      mul_b_d   = mul_op_b;
      mul_acc_d = '0;
      mul_cnt_d = c_cnt_w'(WIDTH);
      mul_run_d = 1'b1;
    end else if (mul_run_q) begin
      mul_acc_d = mul_step;
      mul_b_d   = {mul_b_q[WIDTH-2:0], 1'b0};
      mul_cnt_d = mul_cnt_q - c_cnt_w'(1);
      if (mul_cnt_q == c_cnt_w'(1)) begin
        mul_run_d  = 1'b0;
        mul_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      rx_q        <= '0;
      ry_q        <= '0;
      r_inf_q     <= 1'b0;
      err_q       <= 1'b0;
      mode_q      <= 1'b0;
      p_inf_q     <= 1'b0;
      q_inf_q     <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
      qx_q        <= '0;
      qy_q        <= '0;
`ifdef ECC_DBL_EN
      dbl_q       <= 1'b0;
`endif
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_inf_q   <= 1'b0;
      res_err_q   <= 1'b0;
      num_q       <= '0;
      lam_q       <= '0;
      tmp_q       <= '0;
      u_q         <= '0;
      v_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      mul_pend_q  <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_acc_q   <= '0;
      mul_cnt_q   <= '0;
      mul_run_q   <= 1'b0;
      mul_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      r_inf_q     <= r_inf_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
      p_inf_q     <= p_inf_d;
      q_inf_q     <= q_inf_d;
      px_q        <= px_d;
      py_q        <= py_d;
      qx_q        <= qx_d;
      qy_q        <= qy_d;
`ifdef ECC_DBL_EN
      dbl_q       <= dbl_d;
`endif
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_inf_q   <= res_inf_d;
      res_err_q   <= res_err_d;
      num_q       <= num_d;
      lam_q       <= lam_d;
      tmp_q       <= tmp_d;
      u_q         <= u_d;
      v_q         <= v_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      mul_pend_q  <= mul_pend_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_acc_q   <= mul_acc_d;
      mul_cnt_q   <= mul_cnt_d;
      mul_run_q   <= mul_run_d;
      mul_done_q  <= mul_done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Rx        = rx_q;
  assign bus.Ry        = ry_q;
  assign bus.R_inf     = r_inf_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ecc_point_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ecc_point_unit
// Description : Self-checking bench for ecc_point_unit on the toy curve
//               y^2 = x^3 + 2x + 2 over GF(17) (group of order 19,
//               generator G=(5,1)). Expected points are hand-computed
//               multiples of G. Expectations for doubling follow the
//               ECC_DBL_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_point_unit;

  localparam int         W      = 8;
  localparam logic [7:0] PR     = 8'd17;
  localparam logic [7:0] AC     = 8'd2;
  localparam int         LIMIT  = 6 * W + 32;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ecc_point_unit_if #(.WIDTH(W)) bus_if ();

  ecc_point_unit #(
    .WIDTH (W),
    .PRIME (PR),
    .A     (AC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic       mode;
    logic       p_inf;
    logic       q_inf;
    logic [7:0] px, py, qx, qy;
    logic       e_inf;
    logic       e_err;
    logic [7:0] e_rx, e_ry;
    logic       special;
  } vec_t;

  int checks;
  int errors;
  vec_t vecs[17];

  function automatic vec_t mk(input logic md, input logic pi, input logic qi,
                              input int px, input int py, input int qx, input int qy,
                              input logic ei, input logic ee, input int erx, input int ery,
                              input logic sp);
    vec_t v;
    v.mode = md; v.p_inf = pi; v.q_inf = qi;
    v.px = 8'(px); v.py = 8'(py); v.qx = 8'(qx); v.qy = 8'(qy);
    v.e_inf = ei; v.e_err = ee; v.e_rx = 8'(erx); v.e_ry = 8'(ery);
    v.special = sp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus_if.mode  = v.mode;
    bus_if.P_inf = v.p_inf;
    bus_if.Q_inf = v.q_inf;
    bus_if.Px    = v.px;
    bus_if.Py    = v.py;
    bus_if.Qx    = v.qx;
    bus_if.Qy    = v.qy;
  endtask

  // Pulses in_valid for one cycle; returns at the negedge after capture.
  task automatic start_op(input vec_t v);
    @(negedge clk);
    drive(v);
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic run_check(input vec_t v, input int idx);
    int   lat;
    logic got;
    logic busy1;
    string tag;
    lat = 0; got = 1'b0; busy1 = 1'b0;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    drive(v);
    bus_if.in_valid = 1'b1;
    while (!got && lat < LIMIT + 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      if (lat == 1) busy1 = bus_if.busy;
      if (bus_if.out_valid) got = 1'b1;
    end
    chk({tag, "_out_valid_seen"}, got, 1);
    chk({tag, "_busy_after_start"}, busy1, 1);
    if (got) begin
      chk({tag, "_rx"}, bus_if.Rx, v.e_rx);
      chk({tag, "_ry"}, bus_if.Ry, v.e_ry);
      chk({tag, "_r_inf"}, bus_if.R_inf, v.e_inf);
      chk({tag, "_err"}, bus_if.err, v.e_err);
      chk({tag, "_busy_at_done"}, bus_if.busy, 0);
      if (v.special) chk({tag, "_latency_special"}, lat, 3);
      else           chk({tag, "_latency_bound"}, (lat <= LIMIT) ? 1 : 0, 1);
      @(negedge clk);
      chk({tag, "_single_pulse"}, bus_if.out_valid, 0);
      chk({tag, "_rx_hold"}, bus_if.Rx, v.e_rx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n_ov;
    logic [7:0] cap_rx, cap_ry;
    vec_t v_extra;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // General additions (multiples of G=(5,1))
    vecs[0]  = mk(0, 0, 0,  5,  1,  6,  3, 0, 0, 10,  6, 0);  // G+2G=3G
    vecs[1]  = mk(0, 0, 0,  5,  1, 10,  6, 0, 0,  3,  1, 0);  // G+3G=4G
    vecs[2]  = mk(0, 0, 0,  6,  3, 10,  6, 0, 0,  9, 16, 0);  // 2G+3G=5G
    vecs[3]  = mk(0, 0, 0,  3,  1,  9, 16, 0, 0,  7,  6, 0);  // 4G+5G=9G
    vecs[4]  = mk(0, 0, 0, 16, 13,  0,  6, 0, 0, 16,  4, 0);  // 6G+7G=13G
    vecs[5]  = mk(0, 0, 0, 13,  7,  7, 11, 0, 0,  5, 16, 0);  // 8G+10G=18G
    vecs[6]  = mk(0, 0, 0,  0, 11,  9,  1, 0, 0,  0,  6, 0);  // 12G+14G=7G
    vecs[7]  = mk(0, 0, 0, 16,  4,  6, 14, 0, 0, 13, 10, 0);  // 13G+17G=11G
    // Special cases resolved in CHECK
    vecs[8]  = mk(0, 0, 0,  5,  1,  5, 16, 1, 0,  0,  0, 1);  // G + (-G)
    vecs[9]  = mk(0, 1, 0,  4,  4,  6,  3, 0, 0,  6,  3, 1);  // O + 2G
    vecs[10] = mk(0, 0, 1, 10, 11,  2,  2, 0, 0, 10, 11, 1);  // 16G + O
    vecs[11] = mk(0, 1, 1,  7,  7,  9,  9, 1, 0,  0,  0, 1);  // O + O
    vecs[12] = mk(1, 1, 0,  3,  3,  6,  3, 1, 0,  0,  0, 1);  // 2*O
    vecs[16] = mk(0, 0, 0,  0,  6,  0, 11, 1, 0,  0,  0, 1);  // 7G+12G=O
`ifdef ECC_DBL_EN
    vecs[13] = mk(1, 0, 0,  5,  1,  9,  9, 0, 0,  6,  3, 0);  // 2G
    vecs[14] = mk(0, 0, 0,  5,  1,  5,  1, 0, 0,  6,  3, 0);  // G+G
    vecs[15] = mk(1, 0, 0,  3,  1,  0,  0, 0, 0, 13,  7, 0);  // 2*4G=8G
`else
    vecs[13] = mk(1, 0, 0,  5,  1,  9,  9, 0, 1,  0,  0, 1);
    vecs[14] = mk(0, 0, 0,  5,  1,  5,  1, 0, 1,  0,  0, 1);
    vecs[15] = mk(1, 0, 0,  3,  1,  0,  0, 0, 1,  0,  0, 1);
`endif

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", bus_if.busy, 0);
    chk("reset_out_valid", bus_if.out_valid, 0);
    chk("reset_rx", bus_if.Rx, 0);
    chk("reset_ry", bus_if.Ry, 0);
    chk("reset_r_inf", bus_if.R_inf, 0);
    chk("reset_err", bus_if.err, 0);

    for (int i = 0; i < 17; i++) run_check(vecs[i], i);

    // in_valid pulsed while busy must be ignored
    start_op(vecs[0]);
    repeat (4) @(negedge clk);
    drive(vecs[9]);
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    n_ov = 0; cap_rx = '0; cap_ry = '0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (bus_if.out_valid) begin
        n_ov++;
        cap_rx = bus_if.Rx;
        cap_ry = bus_if.Ry;
      end
    end
    chk("busy_ignore_pulses", n_ov, 1);
    chk("busy_ignore_rx", cap_rx, 10);
    chk("busy_ignore_ry", cap_ry, 6);

    // Reset in the middle of the inversion
    start_op(vecs[5]);
    repeat (3) @(negedge clk);
    chk("midop_busy", bus_if.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bus_if.busy, 0);
    chk("abort_out_valid", bus_if.out_valid, 0);
    chk("abort_rx", bus_if.Rx, 0);
    chk("abort_ry", bus_if.Ry, 0);
    chk("abort_r_inf", bus_if.R_inf, 0);
    chk("abort_err", bus_if.err, 0);
    n_ov = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus_if.out_valid) n_ov++;
    end
    chk("abort_no_out_valid", n_ov, 0);
    v_extra = vecs[3];
    run_check(v_extra, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
